// File: rtl/y86_dmem_responder.sv
// Data-memory responder for the Y86 SEQ core: one outstanding 8-byte request,
// fixed LAT-cycle access latency, little-endian data, AOK/ADR status.
module y86_dmem_responder #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned LAT       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic [2:0]  rsp_stat,
  output logic        busy
);

  localparam int unsigned AW        = $clog2(MEM_BYTES);
  localparam logic [64:0] LAST_BASE = 65'(MEM_BYTES - 8);
  localparam logic [2:0]  STAT_AOK  = 3'd1;
  localparam logic [2:0]  STAT_ADR  = 3'd3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateE;

  stateE         state, nextState;
  logic [3:0]    cnt;
  logic          latWe;
  logic [63:0]   latAddr;
  logic [63:0]   latWdata;
  logic [63:0]   rdataQ;
  logic [2:0]    statQ;
  logic [7:0]    mem [MEM_BYTES];

  logic          lastCycle;
  logic          addrErr;
  logic [AW-1:0] baseIdx;
  logic [63:0]   readWord;

  always_comb begin
    lastCycle = (state == WAIT) && (cnt == 4'(LAT - 1));
    // 65-bit compare so addresses near 2^64 cannot wrap into the valid range
    addrErr   = {1'b0, latAddr} > LAST_BASE;
    baseIdx   = latAddr[AW-1:0];
    readWord  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      readWord[8*i +: 8] = mem[baseIdx + AW'(i)];
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (req_valid) nextState = WAIT;
      WAIT:    if (lastCycle) nextState = RESP;
      RESP:    if (rsp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      latWe    <= 1'b0;
      latAddr  <= '0;
      latWdata <= '0;
      rdataQ   <= '0;
      statQ    <= STAT_AOK;
    end else begin
      if (state == IDLE && req_valid) begin
        cnt      <= '0;
        latWe    <= req_we;
        latAddr  <= req_addr;
        latWdata <= req_wdata;
      end else if (state == WAIT) begin
        cnt <= cnt + 4'd1;
      end
      if (lastCycle) begin
        rdataQ <= (latWe || addrErr) ? '0 : readWord;
        statQ  <= addrErr ? STAT_ADR : STAT_AOK;
      end
    end
  end

  // Storage has no reset; a reset on the commit edge discards the pending write
  always_ff @(posedge clk) begin
    if (rst_n && lastCycle && latWe && !addrErr) begin
      for (int unsigned i = 0; i < 8; i++) begin
        mem[baseIdx + AW'(i)] <= latWdata[8*i +: 8];
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign rsp_rdata = rdataQ;
  assign rsp_stat  = statQ;

endmodule

// File: tb/tb_y86_dmem_responder.sv
// Scoreboard bench for y86_dmem_responder: a byte-array reference model predicts
// each response at issue time; a negedge monitor compares on every rsp handshake.
module tb_y86_dmem_responder;

  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned LAT       = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic [2:0]  rsp_stat;
  logic        busy;

  y86_dmem_responder #(.MEM_BYTES(MEM_BYTES), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_stat  (rsp_stat),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  logic [66:0] expQ [$];
  logic [66:0] monE;
  logic [7:0]  refMem [MEM_BYTES];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: 8 bytes at addr, little-endian, error when addr > MEM_BYTES-8
  function automatic logic [66:0] model(input logic we, input logic [63:0] addr,
                                        input logic [63:0] wdata);
    logic [63:0] r;
    int base;
    r = '0;
    if ({1'b0, addr} > 65'(MEM_BYTES - 8)) return {3'd3, 64'd0};
    base = int'(addr[31:0]);
    for (int i = 0; i < 8; i++) begin
      if (we) refMem[base + i] = wdata[8*i +: 8];
      else    r[8*i +: 8]      = refMem[base + i];
    end
    return {3'd1, r};
  endfunction

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rdata 0x%0h stat %0d, expected no response",
                 rsp_rdata, rsp_stat);
      end else begin
        monE = expQ.pop_front();
        chk("rsp_rdata", rsp_rdata, monE[63:0]);
        chk("rsp_stat", 64'(rsp_stat), 64'(monE[66:64]));
      end
    end
  end

  // Returns at #1 after the accept edge
  task automatic issue(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input bit commit, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    while (n < 50) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no req_ready in 50 cycles, expected accept");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (commit) expQ.push_back(model(we, addr, wdata));
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
  endtask

  task automatic doReq(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input int hold, input bit intrude);
    bit ok;
    int lat;
    logic [63:0] r0;
    logic [2:0]  s0;
    rsp_ready = 1'b0;
    issue(we, addr, wdata, 1'b1, ok);
    if (!ok) return;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_latency", 64'(lat), 64'(LAT));
    if (!rsp_valid) return;
    r0 = rsp_rdata;
    s0 = rsp_stat;
    for (int j = 0; j < hold; j++) begin
      if (intrude) begin
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 64'h100;
        req_wdata = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rdata", rsp_rdata, r0);
      chk("bp_stat", 64'(rsp_stat), 64'(s0));
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("post_hs_req_ready", 64'(req_ready), 64'd1);
    chk("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("post_hs_busy", 64'(busy), 64'd0);
  endtask

  task automatic chkResetOutputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 64'd0);
    chk({tag, "_rsp_stat"}, 64'(rsp_stat), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int prev;
    int acc;
    logic [63:0] a;
    logic [63:0] addrs [4];

    for (int i = 0; i < int'(MEM_BYTES); i++) refMem[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chkResetOutputs("reset");
    rst_n = 1'b1;

    doReq(1'b1, 64'h10, 64'h0123456789ABCDEF, 0, 1'b0);
    doReq(1'b0, 64'h10, 64'h0, 0, 1'b0);

    doReq(1'b1, 64'h20, 64'h0807060504030201, 1, 1'b0);
    doReq(1'b0, 64'h23, 64'h0, 0, 1'b0);

    doReq(1'b1, 64'h3F8, {$urandom, $urandom}, 0, 1'b0);
    doReq(1'b0, 64'h3F8, 64'h0, 0, 1'b0);
    doReq(1'b0, 64'h3F9, 64'h0, 0, 1'b0);
    doReq(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 0, 1'b0);
    doReq(1'b1, 64'h3F9, {$urandom, $urandom}, 0, 1'b0);
    doReq(1'b0, 64'h3F8, 64'h0, 0, 1'b0);

    // Back-pressure with a competing request held during RESP that must be ignored
    doReq(1'b0, 64'h10, 64'h0, 5, 1'b1);
    doReq(1'b0, 64'h100, 64'h0, 0, 1'b0);

    doReq(1'b1, 64'h40, {$urandom, $urandom}, 0, 1'b0);
    issue(1'b1, 64'h40, 64'hDEAD, 1'b0, ok);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chkResetOutputs("midwrite_reset");
    rst_n = 1'b1;
    doReq(1'b0, 64'h40, 64'h0, 0, 1'b0);

    for (int k = 0; k < 4; k++) addrs[k] = 64'($urandom_range(0, 1016));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = addrs[0];
    prev      = 0;
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int n = 0; n < 50 && !ok; n++) begin
        @(negedge clk);
        if (req_ready) ok = 1'b1;
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL b2b_accept_timeout: got no req_ready, expected accept %0d", k);
        break;
      end
      @(posedge clk);
      expQ.push_back(model(1'b0, addrs[k], 64'h0));
      #1;
      acc = cyc;
      if (k > 0) chk("b2b_accept_spacing", 64'(acc - prev), 64'(LAT + 2));
      prev = acc;
      if (k < 3) req_addr = addrs[k+1];
      else       req_valid = 1'b0;
    end
    repeat (LAT + 3) @(posedge clk);
    #1;
    rsp_ready = 1'b0;

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 9))
        8:       a = 64'($urandom_range(1008, 1023));
        9:       a = {$urandom, $urandom};
        default: a = 64'($urandom_range(0, 1023));
      endcase
      doReq(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, $urandom_range(0, 3), 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
